// File: rtl/smi_status_tx.sv
// SMI read-direction responder: serves an 8-byte status packet (9 bytes with XOR checksum
// when SMI_STATUS_CHECKSUM_EN is defined) to the Pi, one byte per synchronised read strobe.
module smi_status_tx #(
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] MAGIC          = 8'hA5,
    parameter int         SYNC_STAGES    = 2
) (
    input  logic        sys_clk,
    input  logic        global_rst,
    input  logic        smi_noe_pi,
    input  logic        smi_nwe_pi,
    input  logic [23:0] line_time,
    input  logic [15:0] frame_count,
    input  logic        fifo_empty,
    output logic [7:0]  smi_data_po,
    output logic        smi_data_oe,
    output logic        pkt_done,
    output logic        rd_err
);

`ifdef SMI_STATUS_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd7;
`endif
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_ADVANCE = 2'd2
    } state_t;

    logic [SYNC_STAGES:0]   noe_sync_q;
    logic [SYNC_STAGES-1:0] nwe_sync_q;
    logic                   noe_fall_q;
    logic                   noe_rise_q;
    state_t                 state_q;
    logic [3:0]             idx_q;
    logic [3:0]             idx_d;
    logic [7:0]             seq_q;
    logic [7:0]             data_q;
    logic                   oe_q;
    logic                   done_q;
    logic                   err_q;
    logic                   to_flag_q;
    logic                   to_flag_d;
    logic [TO_W-1:0]        to_cnt_q;
    logic [63:0]            shadow_q;
    logic [63:0]            snap_s;
    logic                   nwe_low_s;
    logic                   to_count_s;
    logic                   to_fire_s;

    function automatic logic [7:0] pkt_byte(input logic [63:0] sh, input logic [3:0] i);
        logic [7:0] b;
`ifdef SMI_STATUS_CHECKSUM_EN
        if (i == 4'd8) begin
            b = 8'h00;
            for (int k = 0; k < 8; k++) begin
                b = b ^ sh[k*8 +: 8];
            end
        end else begin
            b = sh[{i[2:0], 3'b000} +: 8];
        end
`else
        b = i[3] ? 8'h00 : sh[{i[2:0], 3'b000} +: 8];
`endif
        return b;
    endfunction

    // A timeout firing in the same cycle as a new strobe counts as a fresh packet start.
    always_comb begin
        to_count_s = (state_q == ST_IDLE) && (idx_q != 4'd0);
        to_fire_s  = to_count_s && (to_cnt_q == TO_LAST);
        idx_d      = to_fire_s ? 4'd0 : idx_q;
        to_flag_d  = to_fire_s | to_flag_q;
        nwe_low_s  = ~nwe_sync_q[SYNC_STAGES-1];
        snap_s     = {5'b00000, err_q, fifo_empty, to_flag_d, frame_count, line_time, seq_q, MAGIC};
    end

    // Strobe synchronisers; the registered edge pulses add the extra latency stage.
    always_ff @(posedge sys_clk) begin
        if (global_rst) begin
            noe_sync_q <= '1;
            nwe_sync_q <= '1;
            noe_fall_q <= 1'b0;
            noe_rise_q <= 1'b0;
        end else begin
            noe_sync_q <= {noe_sync_q[SYNC_STAGES-1:0], smi_noe_pi};
            nwe_sync_q <= {nwe_sync_q[SYNC_STAGES-2:0], smi_nwe_pi};
            noe_fall_q <= noe_sync_q[SYNC_STAGES] & ~noe_sync_q[SYNC_STAGES-1];
            noe_rise_q <= ~noe_sync_q[SYNC_STAGES] & noe_sync_q[SYNC_STAGES-1];
        end
    end

    // Idle-timeout counter for abandoned mid-packet reads.
    always_ff @(posedge sys_clk) begin
        if (global_rst) begin
            to_cnt_q <= '0;
        end else if (noe_fall_q || noe_rise_q || to_fire_s) begin
            to_cnt_q <= '0;
        end else if (to_count_s) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_q <= to_cnt_q;
        end
    end

    // Read FSM with snapshot, byte index and registered pad outputs.
    always_ff @(posedge sys_clk) begin
        if (global_rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            seq_q     <= 8'd0;
            data_q    <= 8'd0;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            to_flag_q <= 1'b0;
            shadow_q  <= 64'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    idx_q     <= idx_d;
                    to_flag_q <= to_flag_d;
                    oe_q      <= 1'b0;
                    if (noe_fall_q && nwe_low_s) begin
                        err_q <= 1'b1;
                    end else if (noe_fall_q) begin
                        state_q <= ST_DRIVE;
                        oe_q    <= 1'b1;
                        if (idx_d == 4'd0) begin
                            shadow_q  <= snap_s;
                            seq_q     <= seq_q + 8'd1;
                            to_flag_q <= 1'b0;
                            data_q    <= MAGIC;
                        end else begin
                            data_q <= pkt_byte(shadow_q, idx_d);
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    // Collision also marks the packet in flight so its flags byte reports it.
                    if (nwe_low_s) begin
                        state_q      <= ST_IDLE;
                        oe_q         <= 1'b0;
                        err_q        <= 1'b1;
                        shadow_q[58] <= 1'b1;
                    end else if (noe_rise_q) begin
                        state_q <= ST_ADVANCE;
                        oe_q    <= 1'b0;
                    end else begin
                        state_q <= ST_DRIVE;
                    end
                end
                ST_ADVANCE: begin
                    state_q <= ST_IDLE;
                    if (idx_q == LAST_IDX) begin
                        idx_q  <= 4'd0;
                        done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    oe_q    <= 1'b0;
                end
            endcase
        end
    end

    assign smi_data_po = data_q;
    assign smi_data_oe = oe_q;
    assign pkt_done    = done_q;
    assign rd_err      = err_q;

endmodule

// File: tb/tb_smi_status_tx.sv
// Bench for smi_status_tx: vector table of known packets, randomised packets against a
// byte-level packet model, and hand sequences for timeout, collision, seq wrap and reset.
module tb_smi_status_tx;

    localparam int SYNC = 2;
    localparam int TO   = 4096;
`ifdef SMI_STATUS_CHECKSUM_EN
    localparam int PLEN = 9;
`else
    localparam int PLEN = 8;
`endif

    typedef logic [7:0] pkt_t [9];

    typedef struct {
        logic [23:0] l;
        logic [15:0] f;
        logic        e;
        logic [63:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        noe;
    logic        nwe;
    logic [23:0] lt;
    logic [15:0] fc;
    logic        fe;
    logic [7:0]  data;
    logic        oe;
    logic        done;
    logic        err;

    int          total = 0;
    int          bad = 0;
    int          pd_total = 0;
    logic [7:0]  seq_m;
    logic        err_m;
    logic        to_m;

    smi_status_tx #(.TIMEOUT_CYCLES(TO), .MAGIC(8'hA5), .SYNC_STAGES(SYNC)) dut (
        .sys_clk     (clk),
        .global_rst  (rst),
        .smi_noe_pi  (noe),
        .smi_nwe_pi  (nwe),
        .line_time   (lt),
        .frame_count (fc),
        .fifo_empty  (fe),
        .smi_data_po (data),
        .smi_data_oe (oe),
        .pkt_done    (done),
        .rd_err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) pd_total <= pd_total + 1;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xor8(input pkt_t p);
        logic [7:0] x = 8'h00;
        for (int k = 0; k < 8; k++) x = x ^ p[k];
        return x;
    endfunction

    task automatic build_pkt(input logic [23:0] l, input logic [15:0] f, input logic e,
                             input logic [7:0] s, input logic er, input logic t, output pkt_t p);
        p[0] = 8'hA5;
        p[1] = s;
        p[2] = l[7:0];
        p[3] = l[15:8];
        p[4] = l[23:16];
        p[5] = f[7:0];
        p[6] = f[15:8];
        p[7] = {5'b00000, er, e, t};
        p[8] = xor8(p);
    endtask

    task automatic read_byte(output logic [7:0] b);
        b = 8'h00;
        noe = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == SYNC + 1) chk("oe_before_latency", {63'd0, oe}, 64'd0);
            if (i == SYNC + 2) begin
                chk("oe_at_latency", {63'd0, oe}, 64'd1);
                b = data;
            end
        end
        noe = 1'b1;
        repeat (7) tick();
        chk("oe_after_rise", {63'd0, oe}, 64'd0);
    endtask

    task automatic collide;
        int n = 0;
        noe = 1'b0;
        repeat (SYNC + 3) tick();
        chk("coll_oe_pre", {63'd0, oe}, 64'd1);
        nwe = 1'b0;
        while (oe === 1'b1 && n < SYNC + 2) begin
            tick();
            n++;
        end
        chk("coll_oe_drop", {63'd0, oe}, 64'd0);
        chk("coll_rd_err", {63'd0, err}, 64'd1);
        nwe = 1'b1;
        noe = 1'b1;
        repeat (7) tick();
        chk("rd_err_sticky", {63'd0, err}, 64'd1);
    endtask

    task automatic read_packet(input logic [23:0] l, input logic [15:0] f, input logic e,
                               input int coll_at, input logic mid_en, input logic [23:0] l2,
                               input logic [15:0] f2, input logic e2, output pkt_t got);
        pkt_t       exp;
        int         pd0;
        logic [7:0] b;
        lt = l;
        fc = f;
        fe = e;
        build_pkt(l, f, e, seq_m, err_m, to_m, exp);
        seq_m = seq_m + 8'd1;
        to_m  = 1'b0;
        pd0   = pd_total;
        got[8] = 8'h00;
        for (int k = 0; k < PLEN; k++) begin
            if (k == coll_at) begin
                collide();
                err_m     = 1'b1;
                exp[7][2] = 1'b1;
                exp[8]    = xor8(exp);
            end
            read_byte(b);
            got[k] = b;
            chk($sformatf("byte%0d", k), {56'd0, b}, {56'd0, exp[k]});
            if (k == PLEN - 2) chk("done_early", 64'(pd_total - pd0), 64'd0);
            if (mid_en && k == 2) begin
                lt = l2;
                fc = f2;
                fe = e2;
            end
        end
        chk("done_once", 64'(pd_total - pd0), 64'd1);
    endtask

    initial begin
        vec_t       tbl [4];
        pkt_t       g;
        logic [7:0] b;
        int         guard;

        tbl[0] = '{24'h123456, 16'hBEEF, 1'b0, 64'h00BEEF12345600A5};
        tbl[1] = '{24'h000000, 16'h0000, 1'b1, 64'h02000000000001A5};
        tbl[2] = '{24'hFFFFFF, 16'hFFFF, 1'b0, 64'h00FFFFFFFFFF02A5};
        tbl[3] = '{24'hABCDEF, 16'h1234, 1'b1, 64'h021234ABCDEF03A5};

        rst = 1'b1;
        noe = 1'b1;
        nwe = 1'b1;
        lt  = 24'h0;
        fc  = 16'h0;
        fe  = 1'b0;
        repeat (3) tick();
        chk("rst_data", {56'd0, data}, 64'd0);
        chk("rst_oe", {63'd0, oe}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        tick();
        seq_m = 8'd0;
        err_m = 1'b0;
        to_m  = 1'b0;

        for (int v = 0; v < 4; v++) begin
            read_packet(tbl[v].l, tbl[v].f, tbl[v].e, -1, 1'b0, 24'h0, 16'h0, 1'b0, g);
            chk($sformatf("tbl%0d", v), {g[7], g[6], g[5], g[4], g[3], g[2], g[1], g[0]}, tbl[v].exp);
        end

        read_packet(24'h123456, 16'hBEEF, 1'b0, -1, 1'b1, 24'hFFFFFF, 16'hBEEF, 1'b0, g);
        chk("atomic_b34", {48'd0, g[4], g[3]}, 64'h1234);
        read_packet(24'hFFFFFF, 16'hBEEF, 1'b0, -1, 1'b0, 24'h0, 16'h0, 1'b0, g);
        chk("atomic_next", {40'd0, g[4], g[3], g[2]}, 64'hFFFFFF);

        for (int r = 0; r < 12; r++) begin
            read_packet(24'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), -1,
                        1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom),
                        1'($urandom_range(0, 1)), g);
        end

        lt = 24'h0A0B0C;
        fc = 16'h0D0E;
        fe = 1'b0;
        seq_m = seq_m + 8'd1;
        read_byte(b);
        chk("part_b0", {56'd0, b}, 64'hA5);
        read_byte(b);
        chk("part_b1", {56'd0, b}, {56'd0, seq_m - 8'd1});
        read_byte(b);
        chk("part_b2", {56'd0, b}, 64'h0C);
        repeat (TO + 2) tick();
        to_m = 1'b1;
        read_packet(24'h111111, 16'h2222, 1'b0, -1, 1'b0, 24'h0, 16'h0, 1'b0, g);
        chk("to_flag_set", {63'd0, g[7][0]}, 64'd1);
        read_packet(24'h333333, 16'h4444, 1'b0, -1, 1'b0, 24'h0, 16'h0, 1'b0, g);
        chk("to_flag_clr", {63'd0, g[7][0]}, 64'd0);

        read_packet(24'h123456, 16'hBEEF, 1'b0, 4, 1'b0, 24'h0, 16'h0, 1'b0, g);
        chk("coll_reread_b4", {56'd0, g[4]}, 64'h12);
        chk("coll_flag", {63'd0, g[7][2]}, 64'd1);

        guard = 0;
        while (seq_m != 8'hFF && guard < 300) begin
            read_packet(24'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), -1, 1'b0,
                        24'h0, 16'h0, 1'b0, g);
            guard++;
        end
        chk("wrap_reached", {63'd0, seq_m == 8'hFF}, 64'd1);
        read_packet(24'h5, 16'h6, 1'b0, -1, 1'b0, 24'h0, 16'h0, 1'b0, g);
        chk("seq_ff", {56'd0, g[1]}, 64'hFF);
        read_packet(24'h7, 16'h8, 1'b1, -1, 1'b0, 24'h0, 16'h0, 1'b0, g);
        chk("seq_00", {56'd0, g[1]}, 64'h00);

        noe = 1'b0;
        repeat (SYNC + 3) tick();
        chk("mid_oe", {63'd0, oe}, 64'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_oe", {63'd0, oe}, 64'd0);
        chk("mid_rst_err", {63'd0, err}, 64'd0);
        chk("mid_rst_data", {56'd0, data}, 64'd0);
        noe = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        seq_m = 8'd0;
        err_m = 1'b0;
        to_m  = 1'b0;
        read_packet(24'h0F0F0F, 16'hF0F0, 1'b1, -1, 1'b0, 24'h0, 16'h0, 1'b0, g);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
